// File: rtl/dsp_requant.sv
// rtl/dsp_requant.sv - two-stage requantiser: round/shift, then saturate or wrap, with valid/ready flow control
// Stage 1 works in IN_W+1 bits so the rounding add cannot overflow; stage 2 narrows to OUT_W and keeps statistics.
module dsp_requant #(
  parameter int IN_W    = 64,
  parameter int OUT_W   = 24,
  parameter int SHIFT_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               round_en,
  input  logic               sat_en,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               clr_stat,
  output logic               sat_sticky,
  output logic [CNT_W-1:0]   sat_count
);
  localparam logic [SHIFT_W-1:0] MAX_S = SHIFT_W'(IN_W - 1);
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                 s1_valid;
  logic                 s1_sat_en;
  logic signed [IN_W:0] s1_data;
  logic                 s2_loading;
  logic [SHIFT_W-1:0]   s_eff;
  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] bias;
  logic signed [IN_W:0] rounded;
  logic signed [IN_W:0] shifted;
  logic                 over;
  logic                 under;
  logic                 sat_evt;
  logic [OUT_W-1:0]     reduced;

  assign s2_loading = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_loading;

  always_comb begin
    s_eff   = (int'(shift) > IN_W - 1) ? MAX_S : shift;
    ext     = {in_data[IN_W-1], in_data};
    bias    = '0;
    if (round_en && (s_eff != '0))
      bias = (IN_W+1)'(1) << (s_eff - SHIFT_W'(1));
    rounded = ext + bias;
    shifted = rounded >>> s_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_sat_en <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data   <= shifted;
        s1_sat_en <= sat_en;
      end
    end
  end

  // Wrap mode never raises an event, even when the low bits lose information.
  always_comb begin
    over    = s1_data > MAX_V;
    under   = s1_data < MIN_V;
    sat_evt = s1_sat_en && (over || under);
    reduced = s1_data[OUT_W-1:0];
    if (sat_evt)
      reduced = over ? MAX_V[OUT_W-1:0] : MIN_V[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_loading) begin
      out_valid <= s1_valid;
      if (s1_valid)
        out_data <= reduced;
    end
  end

  // A clear in the same cycle as an event wins; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (clr_stat) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (s2_loading && s1_valid && sat_evt) begin
      sat_sticky <= 1'b1;
      if (sat_count != '1)
        sat_count <= sat_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dsp_requant.sv
// tb/tb_dsp_requant.sv - self-checking bench for dsp_requant
// Constant vector table, hand-built flow-control/reset sequences and randomized streams against an arithmetic model.
module tb_dsp_requant;
  localparam int IN_W    = 64;
  localparam int OUT_W   = 24;
  localparam int SHIFT_W = 6;
  localparam int CNT_W   = 4;
  localparam logic signed [127:0] QMAX = 128'sd8388607;
  localparam logic signed [127:0] QMIN = -128'sd8388608;

  logic               clk = 1'b0;
  logic               rst;
  logic [IN_W-1:0]    in_data;
  logic               in_valid;
  logic               in_ready;
  logic [SHIFT_W-1:0] shift;
  logic               round_en;
  logic               sat_en;
  logic [OUT_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               clr_stat;
  logic               sat_sticky;
  logic [CNT_W-1:0]   sat_count;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] din;
    int          sh;
    bit          rnd;
    bit          sat;
    logic [23:0] exp;
    bit          evt;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dsp_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .shift(shift), .round_en(round_en), .sat_en(sat_en), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .clr_stat(clr_stat),
    .sat_sticky(sat_sticky), .sat_count(sat_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: floor((x + half) / 2^s) in wide arithmetic, then clamp or keep low bits.
  function automatic void model(input logic [63:0] x, input int sh, input bit rnd, input bit sat,
                                output logic [23:0] y, output bit ev);
    logic signed [127:0] v, d, q;
    int s;
    s = (sh > IN_W - 1) ? IN_W - 1 : sh;
    v = {{64{x[63]}}, x};
    d = 1;
    d = d << s;
    if (rnd && s > 0) v = v + d / 2;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    ev = 1'b0;
    y  = q[23:0];
    if (sat) begin
      if (q > QMAX) begin y = 24'h7FFFFF; ev = 1'b1; end
      else if (q < QMIN) begin y = 24'h800000; ev = 1'b1; end
    end
  endfunction

  task automatic add_vec(input logic [63:0] d, input int sh, input bit rnd, input bit sat,
                         input logic [23:0] e, input bit ev);
    vec_t v;
    v.din = d; v.sh = sh; v.rnd = rnd; v.sat = sat; v.exp = e; v.evt = ev;
    vecs.push_back(v);
  endtask

  task automatic clear_stats();
    @(negedge clk); clr_stat = 1'b1;
    @(negedge clk); clr_stat = 1'b0;
    chk("clr_count", sat_count, 0);
  endtask

  // One isolated beat; returns the result and the cycles until out_valid.
  task automatic send_one(input logic [63:0] d, input int sh, input bit rnd, input bit sat,
                          input bit clr_mid, output logic [23:0] y, output int lat);
    @(negedge clk);
    in_data = d; shift = SHIFT_W'(sh); round_en = rnd; sat_en = sat;
    in_valid = 1'b1; out_ready = 1'b1;
    lat = 0; y = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      clr_stat = clr_mid && (i == 1);
      if (out_valid) begin lat = i; y = out_data; break; end
    end
    clr_stat = 1'b0;
  endtask

  task automatic run_stream(input int n, input bit legacy, output int ev_n);
    logic [23:0] exp_q[$];
    logic [23:0] held, y, e;
    logic [63:0] d;
    bit stalled, ev;
    int sent, got, cyc, sh;
    bit rnd, sat;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; ev_n = 0; held = '0;
    while (got < n && cyc < 20000) begin
      @(negedge clk);
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
      end
      if (sent < n && (legacy || $urandom_range(3) != 0)) begin
        d = {$urandom, $urandom};
        case ($urandom_range(2))
          0: d = {{32{d[31]}}, d[31:0]};
          1: d = {{40{d[23]}}, d[23:0]};
          default: ;
        endcase
        sh  = legacy ? 8 : $urandom_range(63);
        rnd = legacy ? 1'b0 : 1'($urandom_range(1));
        sat = legacy ? 1'b0 : 1'($urandom_range(1));
        in_data = d; shift = SHIFT_W'(sh); round_en = rnd; sat_en = sat; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = legacy ? 1'b1 : 1'($urandom_range(1));
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk(legacy ? "legacy_data" : "rand_data", out_data, e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        if (legacy) begin
          y = in_data[31:8];
        end else begin
          model(in_data, int'(shift), round_en, sat_en, y, ev);
          if (ev) ev_n++;
        end
        exp_q.push_back(y);
        sent++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      cyc++;
    end
    chk("stream_done", got, n);
    chk("stream_queue_empty", exp_q.size(), 0);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] y;
    int lat, ev_sum, ev_n, mc;
    bit stale;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; shift = '0; round_en = 1'b0;
    sat_en = 1'b0; out_ready = 1'b1; clr_stat = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_sat_sticky", sat_sticky, 0);
    @(negedge clk); rst = 1'b0;

    add_vec(64'h0000_0012_3456_789A, 8,  0, 0, 24'h345678, 0);
    add_vec(64'd24,                  4,  1, 0, 24'h000002, 0);
    add_vec(64'd23,                  4,  1, 0, 24'h000001, 0);
    add_vec(64'hFFFF_FFFF_FFFF_FFE8, 4,  1, 0, 24'hFFFFFF, 0);
    add_vec(64'd5,                   0,  1, 0, 24'h000005, 0);
    add_vec(64'hFFFF_FFFF_FFFF_FFF9, 0,  1, 1, 24'hFFFFF9, 0);
    add_vec(64'h0000_0000_0080_0000, 0,  0, 1, 24'h7FFFFF, 1);
    add_vec(64'hFFFF_FFFF_FF7F_FFFF, 0,  0, 1, 24'h800000, 1);
    add_vec(64'h0000_0000_0080_0000, 0,  0, 0, 24'h800000, 0);
    add_vec(64'hFFFF_FFFF_FF7F_FFFF, 0,  0, 0, 24'h7FFFFF, 0);
    add_vec(64'h0000_0000_007F_FFFF, 0,  0, 1, 24'h7FFFFF, 0);
    add_vec(64'hFFFF_FFFF_FF80_0000, 0,  0, 1, 24'h800000, 0);
    add_vec(64'h8000_0000_0000_0000, 63, 0, 0, 24'hFFFFFF, 0);
    add_vec(64'h7FFF_FFFF_FFFF_FFFF, 63, 1, 1, 24'h000001, 0);
    add_vec(64'h7FFF_FFFF_FFFF_FFFF, 4,  1, 1, 24'h7FFFFF, 1);

    clear_stats();
    ev_sum = 0;
    foreach (vecs[i]) begin
      send_one(vecs[i].din, vecs[i].sh, vecs[i].rnd, vecs[i].sat, 1'b0, y, lat);
      chk($sformatf("vec%0d_data", i), y, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      if (vecs[i].evt) ev_sum++;
    end
    chk("table_sat_count", sat_count, (ev_sum > 15) ? 15 : ev_sum);
    chk("table_sat_sticky", sat_sticky, 1);

    // counter saturates at all-ones and updates in the cycle out_valid rises
    clear_stats();
    mc = 0;
    for (int i = 0; i < 20; i++) begin
      send_one(64'h0000_0001_0000_0000, 0, 1'b0, 1'b1, 1'b0, y, lat);
      if (mc < 15) mc++;
      chk($sformatf("evt%0d_count", i), sat_count, mc);
    end
    chk("evt_sticky", sat_sticky, 1);
    send_one(64'h0000_0001_0000_0000, 0, 1'b0, 1'b1, 1'b1, y, lat);
    chk("clr_evt_data", y, 24'h7FFFFF);
    chk("clr_evt_count", sat_count, 0);
    chk("clr_evt_sticky", sat_sticky, 0);
    send_one(64'hFFFF_FF00_0000_0000, 0, 1'b0, 1'b1, 1'b0, y, lat);
    chk("post_clr_count", sat_count, 1);

    // two beats buffered with out_ready low, then drained in order
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd5; shift = '0; round_en = 1'b0; sat_en = 1'b0;
    #1 chk("bp_ready0", in_ready, 1);
    @(negedge clk); in_data = 64'd6;
    #1 chk("bp_ready1", in_ready, 1);
    @(negedge clk); in_data = 64'd7;
    #1 chk("bp_ready2", in_ready, 0);
    chk("bp_head", out_data, 24'd5);
    @(negedge clk);
    #1 chk("bp_ready3", in_ready, 0);
    chk("bp_head_hold", out_data, 24'd5);
    out_ready = 1'b1;
    #1 chk("bp_ready_comb", in_ready, 1);
    @(negedge clk); in_valid = 1'b0;
    chk("bp_second", out_data, 24'd6);
    @(negedge clk);
    chk("bp_third", out_data, 24'd7);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    run_stream(1000, 1'b1, ev_n);
    clear_stats();
    run_stream(300, 1'b0, ev_n);
    chk("rand_sat_count", sat_count, (ev_n > 15) ? 15 : ev_n);
    chk("rand_sat_sticky", sat_sticky, ev_n > 0);

    // asynchronous reset with two saturating beats in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h0000_0100_0000_0000; sat_en = 1'b1; shift = '0;
    @(negedge clk);
    @(negedge clk); in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_count_nz", sat_count != 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_sat_count", sat_count, 0);
    chk("arst_sat_sticky", sat_sticky, 0);
    rst = 1'b0; out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("no_stale_beat", stale, 0);
    send_one(64'h0000_0000_0000_1234, 4, 1'b0, 1'b0, 1'b0, y, lat);
    chk("post_rst_data", y, 24'h000123);
    chk("post_rst_latency", lat, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dsp_requant.md
# dsp_requant

Parametrised, pipelined requantiser that converts a wide signed accumulator sample to a narrower signed output word. It applies a runtime right shift, optional round-half-up and optional saturation, and keeps saturation statistics. It sits between the wide MAC/filter outputs and the 24-bit DAC/processing path. It supersedes the fixed bit-slice converter: with `shift`=8, rounding off and saturation off, it reproduces `in_data[31:8]` for IN_W=64, OUT_W=24. Unlike that converter, it adds valid/ready flow control.

## Interface
- `IN_W`, 64, input sample width (signed), ≥ OUT_W+1
- `OUT_W`, 24, output sample width (signed), ≥ 2
- `SHIFT_W`, 6, width of `shift`; must satisfy 2^SHIFT_W ≥ IN_W
- `CNT_W`, 16, width of saturation event counter

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  IN_W  signed input sample
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  block can accept a beat this cycle
- `shift`  in  SHIFT_W  right-shift amount, sampled with each accepted beat
- `round_en`  in  1  1 = round half up before shifting, sampled per beat
- `sat_en`  in  1  1 = clamp to OUT_W range, 0 = wrap (keep low OUT_W bits), sampled per beat
- `out_data`  out  OUT_W  signed result
- `out_valid`  out  1  result present
- `out_ready`  in  1  downstream accepts result
- `clr_stat`  in  1  synchronous clear of `sat_sticky` and `sat_count`
- `sat_sticky`  out  1  set when any beat was clamped since last clear
- `sat_count`  out  CNT_W  number of clamped beats; saturates at all-ones

## Operation
- A beat is accepted when `in_valid && in_ready`. `shift`, `round_en` and `sat_en` are captured with that beat, so configuration may change beat-to-beat.
- Effective shift: s = min(`shift`, IN_W-1).
- Stage 1 (round and shift): extend to IN_W+1 bits. If `round_en` and s>0, add 2^(s-1). Then arithmetic right shift by s. The result is held in IN_W+1 bits, so the rounding add never overflows.
- Stage 2 (range reduction): let max = 2^(OUT_W-1)-1 and min = -2^(OUT_W-1).
  - `sat_en`=1: clamp to [min, max]. A beat is a saturation event when clamping changed its value.
  - `sat_en`=0: take the low OUT_W bits (two's-complement wrap). There is never a saturation event in this mode.
- Statistics are updated when a stage-2 result is loaded:
  - On an event, `sat_sticky` is set and `sat_count` increments.
  - `sat_count` holds at 2^CNT_W-1 and does not wrap.
  - If `clr_stat` and an event occur in the same cycle, the clear wins: both counters go to 0 and that event is not counted.
- Flow control: each stage has a valid bit and loads when it is empty or its content is being consumed that cycle.
  - `in_ready` = !s1_valid || s2_loading, where s2_loading = !out_valid || `out_ready`.
  - With `out_ready` held high the block is fully pipelined at 1 beat/clock.
  - When `out_ready` is low, data is held stable: `out_data` and `out_valid` must not change while `out_valid && !out_ready`.
- Reset (asynchronous, any time, including mid-stream): the stage valid bits, `out_valid`, `out_data`, `sat_sticky` and `sat_count` go to 0, and `in_ready` goes to 1. In-flight beats are discarded.

## Timing
- Latency is 2 clocks from input handshake to `out_valid`, with no backpressure.
- Throughput is 1 beat per clock.
- Up to 2 beats may be buffered during a stall. `in_ready` drops one cycle after `out_ready` falls only if stage 1 is also full.
- `in_ready` depends combinationally on `out_ready`. This is the only combinational input-to-output path.
- `sat_sticky` and `sat_count` reflect an event in the same cycle that `out_valid` rises for that beat.
- `clr_stat` takes effect on the next edge.
- Release of `rst` is asynchronous to the clock. The first beat is accepted on the first edge after release.

## Test plan
- Legacy equivalence: IN_W=64, OUT_W=24, shift=8, round_en=0, sat_en=0, in_data=64'h0000_0012_3456_789A → out_data=24'h345678 two clocks later. Also check 1000 random beats against `in_data[31:8]`.
- Rounding: shift=4, round_en=1. Inputs 24 → 2 and 23 → 1. Input -24 → -1 (half rounds toward +∞). With shift=0 the input passes unchanged and no add occurs.
- Saturation: sat_en=1, shift=0. Input 2^23 → out 24'h7FFFFF. Input -2^23-1 → 24'h800000. After these, sat_count=2 and sat_sticky=1. The same inputs with sat_en=0 give wrap values 24'h800000 and 24'h7FFFFF, and sat_count is unchanged.
- Backpressure: stream 10 beats with out_ready toggling randomly. No loss, no duplication, order preserved, and out_data stays stable while stalled. in_ready goes low after 2 beats are buffered with out_ready=0.
- Statistics edges: preload sat_count near all-ones (CNT_W=4) and drive 20 events → count holds at 15. Assert clr_stat in the same cycle as an event → sat_count=0, sat_sticky=0.
- Reset mid-stream: assert rst with 2 beats in flight. Outputs go to 0 and in_ready to 1 immediately, without waiting for a clock edge. After release, no stale beat appears, and a new beat emerges 2 clocks after acceptance.
